ibex_multdiv_iter: RTL

Parametrised iterative multiply/divide unit for the execution stage. It sits beside the ALU and accepts one RV32M-style operation at a time: MUL/MULH*, DIV[U], REM[U]. Operand width and multiplier radix (bits retired per cycle) are parameters. Compared with the fixed-width units, it adds a start/busy/valid handshake, an abort input and single-cycle handling of the division corner cases.

---
 rtl/ibex_multdiv_iter.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ibex_multdiv_iter.sv
// ibex_multdiv_iter
// Iterative multiply/divide unit for the execution stage. One operation is
// accepted at a time through a start/busy/valid handshake:
//   - MUL / MULH / MULHSU / MULHU retire MUL_BITS multiplier bits per cycle.
//   - DIV / REM (signed and unsigned) use a restoring divider, one quotient
//     bit per cycle.
//   - Divide-by-zero and signed overflow finish in a single cycle.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   en_i            start request, only looked at while not busy
//   operator_i      00 MUL, 01 MULH, 10 DIV, 11 REM
//   signed_mode_i   bit0 op_a signed, bit1 op_b signed (DIV/REM use bit0 for both)
//   op_a_i, op_b_i  operands, only sampled on acceptance
//   kill_i          abort the operation in flight (wins over en_i)
//   busy_o          operation in progress (MUL or DIV state)
//   valid_o         one-cycle completion pulse
//   result_o        registered result, held until the next completion
module ibex_multdiv_iter #(
   parameter int WIDTH    = 32,
   parameter int MUL_BITS = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [1:0]       operator_i,
   input  logic [1:0]       signed_mode_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic             kill_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int MUL_ITERS = WIDTH / MUL_BITS;
   localparam int CNT_W     = $clog2(WIDTH + 1);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   // Reject parameter combinations the datapath cannot support.
   generate
      if (WIDTH < 8 || (WIDTH % 2) != 0) begin : g_bad_width
         $error("ibex_multdiv_iter: WIDTH must be >= 8 and even");
      end
      if (MUL_BITS < 1 || (WIDTH % MUL_BITS) != 0) begin : g_bad_mul_bits
         $error("ibex_multdiv_iter: MUL_BITS must divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 sel_hi_q, sel_hi_d;     // MULH high half, or REM instead of DIV
   logic                 neg_res_q, neg_res_d;   // negate product / quotient
   logic                 neg_rem_q, neg_rem_d;   // negate remainder
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;       // shifted multiplicand; low half is the divisor in DIV
   logic [WIDTH-1:0]     shreg_q, shreg_d;       // multiplier, or dividend shifting into quotient
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     result_q, result_d;

   // Operand sign handling. DIV/REM take the signedness of both operands
   // from bit0 so that only the 00 and 11 modes are meaningful there.
   logic             a_signed, b_signed;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   always_comb begin
      a_signed = signed_mode_i[0];
      b_signed = operator_i[1] ? signed_mode_i[0] : signed_mode_i[1];
      a_neg    = a_signed & op_a_i[WIDTH-1];
      b_neg    = b_signed & op_b_i[WIDTH-1];
      a_mag    = a_neg ? -op_a_i : op_a_i;
      b_mag    = b_neg ? -op_b_i : op_b_i;
   end

   // Multiply step: add the partial product of the already-shifted
   // multiplicand and the next multiplier digit; the final product is
   // sign-corrected over the full double-width value.
   logic [MUL_BITS-1:0] mul_digit;
   logic [2*WIDTH-1:0]  mul_pp;
   logic [2*WIDTH-1:0]  mul_acc_next;
   logic [2*WIDTH-1:0]  mul_product;

   always_comb begin
      mul_digit    = shreg_q[MUL_BITS-1:0];
      mul_pp       = mcand_q * {{(2*WIDTH-MUL_BITS){1'b0}}, mul_digit};
      mul_acc_next = acc_q + mul_pp;
      mul_product  = neg_res_q ? -mul_acc_next : mul_acc_next;
   end

   // Restoring divide step. The shifted remainder needs one extra bit; the
   // top bit of the trial difference is set exactly when the subtraction
   // would go negative.
   logic [WIDTH:0]   div_shifted;
   logic [WIDTH:0]   div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] quo_final;
   logic [WIDTH-1:0] rem_final;

   always_comb begin
      div_shifted = {rem_q, shreg_q[WIDTH-1]};
      div_diff    = div_shifted - {1'b0, mcand_q[WIDTH-1:0]};
      div_ge      = ~div_diff[WIDTH];
      rem_next    = div_ge ? div_diff[WIDTH-1:0] : div_shifted[WIDTH-1:0];
      quo_next    = {shreg_q[WIDTH-2:0], div_ge};
      quo_final   = neg_res_q ? -quo_next : quo_next;
      rem_final   = neg_rem_q ? -rem_next : rem_next;
   end

   // Next-state and datapath control. A new operation can be accepted both
   // from IDLE and from DONE, which gives back-to-back throughput; kill_i
   // always returns to IDLE without touching result_q.
   logic start;
   logic div_by_zero;
   logic div_ovf;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_hi_d  = sel_hi_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      shreg_d   = shreg_q;
      rem_d     = rem_q;
      result_d  = result_q;

      start       = en_i & ~kill_i & ((state_q == IDLE) | (state_q == DONE));
      div_by_zero = (op_b_i == '0);
      div_ovf     = signed_mode_i[0] & (op_a_i == MOST_NEG) & (op_b_i == ALL_ONES);

      case (state_q)
         MUL: begin
            if (kill_i) begin
               state_d = IDLE;
            end else begin
               acc_d   = mul_acc_next;
               mcand_d = mcand_q << MUL_BITS;
               shreg_d = shreg_q >> MUL_BITS;
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  result_d = sel_hi_q ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];
                  state_d  = DONE;
               end
            end
         end
         DIV: begin
            if (kill_i) begin
               state_d = IDLE;
            end else begin
               rem_d   = rem_next;
               shreg_d = quo_next;
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  result_d = sel_hi_q ? rem_final : quo_final;
                  state_d  = DONE;
               end
            end
         end
         default: begin
            // IDLE and DONE both fall back to IDLE unless a start arrives.
            state_d = IDLE;
            if (start) begin
               sel_hi_d = operator_i[0];
               acc_d    = '0;
               rem_d    = '0;
               if (!operator_i[1]) begin
                  mcand_d   = {{WIDTH{1'b0}}, a_mag};
                  shreg_d   = b_mag;
                  neg_res_d = a_neg ^ b_neg;
                  cnt_d     = CNT_W'(MUL_ITERS);
                  state_d   = MUL;
               end else if (div_by_zero) begin
                  result_d = operator_i[0] ? op_a_i : ALL_ONES;
                  state_d  = DONE;
               end else if (div_ovf) begin
                  result_d = operator_i[0] ? '0 : op_a_i;
                  state_d  = DONE;
               end else begin
                  mcand_d   = {{WIDTH{1'b0}}, b_mag};
                  shreg_d   = a_mag;
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  cnt_d     = CNT_W'(WIDTH);
                  state_d   = DIV;
               end
            end
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sel_hi_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_q     <= '0;
         mcand_q   <= '0;
         shreg_q   <= '0;
         rem_q     <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_hi_q  <= sel_hi_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         shreg_q   <= shreg_d;
         rem_q     <= rem_d;
         result_q  <= result_d;
      end
   end

   assign busy_o   = (state_q == MUL) || (state_q == DIV);
   assign valid_o  = (state_q == DONE);
   assign result_o = result_q;

endmodule
